// File: rtl/serial_adder.sv
// Digit-serial ripple adder: WIDTH-bit a + b + cin, DIGIT bits per cycle through one shared slice.
// Latency: STEPS = WIDTH/DIGIT cycles from accepted start to the one-cycle done pulse.
// Backpressure: none; start is taken only in IDLE/DONE and is silently ignored while busy.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    // Reject geometries where the slice does not tile the operand exactly.
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("serial_adder: DIGIT must divide WIDTH and satisfy 1 <= DIGIT <= WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // One DIGIT-wide full-adder slice working on the low digit of the shift registers.
    logic [DIGIT-1:0]  slice_a;
    logic [DIGIT-1:0]  slice_b;
    logic [DIGIT:0]    slice_sum;
    logic              carry_into_top;

    assign slice_a   = a_q[DIGIT-1:0];
    assign slice_b   = b_q[DIGIT-1:0];
    assign slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{DIGIT{1'b0}}, carry_q};
    // Carry entering the top bit of the slice: recovered from that bit's sum and operands.
    assign carry_into_top = slice_a[DIGIT-1] ^ slice_b[DIGIT-1] ^ slice_sum[DIGIT-1];

    // Next-state and datapath update: accept, shift one digit per cycle, finish on the last step.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_sum[DIGIT];
                // Sum digits enter at the top and walk down, so the LSB digit lands at bit 0.
                s_d     = (s_q >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                    cnt_d   = cnt_q;
                    cout_d  = slice_sum[DIGIT];
                    ovf_d   = carry_into_top ^ slice_sum[DIGIT];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == ST_RUN);
    assign done_o = (state_q == ST_DONE);
    assign s_o    = s_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder across four geometries (8/1, 1/1, 8/2, 16/4) sharing one clock and reset.
// A vector table plus random operations are checked against an arithmetic model of a + b + cin.
// Hand sequences cover reset mid-operation, start ignored while busy and back-to-back starts.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_c = 1'b0;
    logic [15:0] a_c = '0;
    logic [15:0] b_c = '0;
    logic        ci_c = 1'b0;
    int          sel = 0;

    logic [3:0]  st;
    logic [3:0]  busy_v, done_v, co_v, ov_v;
    logic [7:0]  s_w8d1, s_w8d2;
    logic [0:0]  s_w1d1;
    logic [15:0] s_w16d4;

    logic        busy_m, done_m, co_m, ov_m;
    logic [15:0] s_m;

    int n_checks = 0;
    int n_errors = 0;

    int wid[4]   = '{8, 1, 8, 16};
    int steps[4] = '{8, 1, 4, 4};

    always #5 clk = ~clk;

    assign st = start_c ? (4'b0001 << sel) : 4'b0000;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk_i(clk), .rst_i(rst), .start_i(st[0]), .a_i(a_c[7:0]), .b_i(b_c[7:0]), .cin_i(ci_c),
        .busy_o(busy_v[0]), .done_o(done_v[0]), .s_o(s_w8d1), .cout_o(co_v[0]), .ovf_o(ov_v[0]));
    serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1d1 (
        .clk_i(clk), .rst_i(rst), .start_i(st[1]), .a_i(a_c[0:0]), .b_i(b_c[0:0]), .cin_i(ci_c),
        .busy_o(busy_v[1]), .done_o(done_v[1]), .s_o(s_w1d1), .cout_o(co_v[1]), .ovf_o(ov_v[1]));
    serial_adder #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
        .clk_i(clk), .rst_i(rst), .start_i(st[2]), .a_i(a_c[7:0]), .b_i(b_c[7:0]), .cin_i(ci_c),
        .busy_o(busy_v[2]), .done_o(done_v[2]), .s_o(s_w8d2), .cout_o(co_v[2]), .ovf_o(ov_v[2]));
    serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
        .clk_i(clk), .rst_i(rst), .start_i(st[3]), .a_i(a_c), .b_i(b_c), .cin_i(ci_c),
        .busy_o(busy_v[3]), .done_o(done_v[3]), .s_o(s_w16d4), .cout_o(co_v[3]), .ovf_o(ov_v[3]));

    // Route the selected instance's outputs onto common observation signals.
    always_comb begin
        busy_m = busy_v[sel[1:0]];
        done_m = done_v[sel[1:0]];
        co_m   = co_v[sel[1:0]];
        ov_m   = ov_v[sel[1:0]];
        s_m    = '0;
        case (sel)
            0:       s_m = {8'h00, s_w8d1};
            1:       s_m = {15'h0000, s_w1d1};
            2:       s_m = {8'h00, s_w8d2};
            default: s_m = s_w16d4;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain modular addition; signed overflow when like-signed operands give an unlike-signed sum.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b, input logic ci,
                                  output logic [15:0] s, output logic co, output logic ov);
        logic [16:0] mask;
        logic [16:0] full;
        mask = (17'd1 << w) - 17'd1;
        full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 17'(ci);
        s    = 16'(full & mask);
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    endfunction

    // One complete add on instance 'id'; returns on the negedge where done is seen.
    task automatic op(input int id, input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic [15:0] es, input logic eco, input logic eov,
                      input string nm, input bit pulse_chk);
        int lat;
        sel     = id;
        start_c = 1'b1;
        a_c     = a;
        b_c     = b;
        ci_c    = ci;
        @(negedge clk);
        start_c = 1'b0;
        a_c     = 16'($urandom);
        b_c     = 16'($urandom);
        ci_c    = 1'($urandom);
        chk({nm, "_busy_after_accept"}, 64'(busy_m), 64'(1));
        chk({nm, "_done_after_accept"}, 64'(done_m), 64'(steps[id] == 0));
        lat = 0;
        while (done_m !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(steps[id]));
        chk({nm, "_s"}, 64'(s_m), 64'(es));
        chk({nm, "_cout"}, 64'(co_m), 64'(eco));
        chk({nm, "_ovf"}, 64'(ov_m), 64'(eov));
        if (pulse_chk) begin
            @(negedge clk);
            chk({nm, "_done_one_cycle"}, 64'(done_m), 64'(0));
            chk({nm, "_idle_not_busy"}, 64'(busy_m), 64'(0));
        end
    endtask

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] es, ra, rb;
        logic        eco, eov, rc;
        int          dones, dlat;
        logic [15:0] ds;

        tbl[0] = '{0, 16'h005A, 16'h003C, 1'b0, 16'h0096, 1'b0, 1'b1};
        tbl[1] = '{0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{0, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[3] = '{0, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1};
        tbl[4] = '{0, 16'h00FF, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 1'b0};
        tbl[5] = '{3, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{2, 16'h0055, 16'h00AA, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{3, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        // Reset state of every instance.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sel = i;
            #1;
            chk($sformatf("reset%0d_busy", i), 64'(busy_m), 64'(0));
            chk($sformatf("reset%0d_done", i), 64'(done_m), 64'(0));
            chk($sformatf("reset%0d_s", i), 64'(s_m), 64'(0));
            chk($sformatf("reset%0d_cout", i), 64'(co_m), 64'(0));
            chk($sformatf("reset%0d_ovf", i), 64'(ov_m), 64'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fixed vectors.
        for (int i = 0; i < 8; i++) begin
            op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].co, tbl[i].ov,
               $sformatf("vec%0d", i), 1'b1);
        end

        // W=1: all eight input combinations, issued back to back on the done cycle.
        for (int i = 0; i < 8; i++) begin
            model(1, 16'(i[2]), 16'(i[1]), i[0], es, eco, eov);
            op(1, 16'(i[2]), 16'(i[1]), i[0], es, eco, eov, $sformatf("w1_combo%0d", i), 1'b0);
        end
        @(negedge clk);

        // W=8,D=2: a second start during RUN must not be queued.
        sel     = 2;
        start_c = 1'b1;
        a_c     = 16'h0010;
        b_c     = 16'h0020;
        ci_c    = 1'b0;
        @(negedge clk);
        chk("ignore_busy", 64'(busy_m), 64'(1));
        a_c = 16'h00FF;
        b_c = 16'h00FF;
        @(negedge clk);
        @(negedge clk);
        start_c = 1'b0;
        dones = 0;
        dlat  = 0;
        ds    = '0;
        for (int j = 3; j <= 14; j++) begin
            @(negedge clk);
            if (done_m === 1'b1) begin
                dones++;
                dlat = j;
                ds   = s_m;
            end
        end
        chk("ignore_done_pulses", 64'(dones), 64'(1));
        chk("ignore_latency", 64'(dlat), 64'(4));
        chk("ignore_s", 64'(ds), 64'(16'h0030));

        // W=8,D=1: reset three steps into an add discards it.
        sel     = 0;
        start_c = 1'b1;
        a_c     = 16'h005A;
        b_c     = 16'h003C;
        ci_c    = 1'b0;
        @(negedge clk);
        start_c = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy_m), 64'(0));
        chk("midrst_done", 64'(done_m), 64'(0));
        chk("midrst_s", 64'(s_m), 64'(0));
        chk("midrst_cout", 64'(co_m), 64'(0));
        chk("midrst_ovf", 64'(ov_m), 64'(0));
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_m === 1'b1) dones++;
        end
        chk("midrst_no_done", 64'(dones), 64'(0));
        op(0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, "after_rst", 1'b1);

        // W=16,D=4: start on the done cycle is accepted immediately.
        op(3, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, "b2b_first", 1'b0);
        op(3, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "b2b_second", 1'b1);

        // Random operations on all geometries against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            int id;
            id = int'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if (wid[id] < 16) begin
                ra = ra & ((16'd1 << wid[id]) - 16'd1);
                rb = rb & ((16'd1 << wid[id]) - 16'd1);
            end
            model(wid[id], ra, rb, rc, es, eco, eov);
            op(id, ra, rb, rc, es, eco, eov, $sformatf("rand%0d_id%0d", i, id), ($urandom_range(0, 1) == 1));
        end
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
